// File: rtl/bit_link_pkg.sv
// Shared definitions for the 4 kbit/s binary code link (receiver and transmitter).
package bit_link_pkg;

   localparam int CLK_HZ           = 50_000_000;
   localparam int BIT_HZ           = 4000;
   localparam int DEF_CLKS_PER_BIT = CLK_HZ / BIT_HZ;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/rx_sync_2ff.sv
// Two-flop synchronizer for an asynchronous input plus a registered falling-edge detect.
// Flops reset high so an idle-high line never looks like a falling edge out of reset.
module rx_sync_2ff (
   input  logic clk_in,
   input  logic rst_n,
   input  logic async_in,
   output logic rx_s,
   output logic fall_pulse
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_meta <= async_in;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign rx_s       = r_sync;
   assign fall_pulse = r_prev & ~r_sync;

endmodule

// File: rtl/bit_4_rx.sv
// Receive deserializer for the binary code link: start-bit hunt, mid-bit sampling,
// one byte per frame with a one-cycle valid strobe or frame-error strobe.
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | counting to the start-bit midpoint; rejects glitches
// DATA  | sampling DATA_BITS data bits, LSB first, one per bit period
// STOP  | sampling the stop bit; publishes the byte or flags a frame error
module bit_4_rx
   import bit_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk_in,
   input  logic                 rst_n,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int IW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int HALF = CLKS_PER_BIT / 2;

   localparam logic [CW-1:0] TC_HALF  = CW'(HALF - 1);
   localparam logic [CW-1:0] TC_FULL  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

   logic                 w_rx_s;
   logic                 w_fall;

   rx_state_t            r_state;
   rx_state_t            w_state_nxt;
   logic [CW-1:0]        r_cnt;
   logic [CW-1:0]        w_cnt_nxt;
   logic [IW-1:0]        r_idx;
   logic [IW-1:0]        w_idx_nxt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shift_nxt;
   logic [DATA_BITS-1:0] r_data;
   logic [DATA_BITS-1:0] w_data_nxt;
   logic                 r_valid;
   logic                 w_valid_nxt;
   logic                 r_ferr;
   logic                 w_ferr_nxt;

   rx_sync_2ff u_sync (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .async_in   (rx_in),
      .rx_s       (w_rx_s),
      .fall_pulse (w_fall)
   );

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
         r_data  <= w_data_nxt;
         r_valid <= w_valid_nxt;
         r_ferr  <= w_ferr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CW'(1);
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_data_nxt  = r_data;
      w_valid_nxt = 1'b0;
      w_ferr_nxt  = 1'b0;

      case (r_state)
         IDLE: begin
            // Only a fresh edge arms the receiver; a line stuck low stays ignored.
            w_cnt_nxt = '0;
            if (w_fall) begin
               w_state_nxt = START;
            end
         end
         START: begin
            if (r_cnt == TC_HALF) begin
               w_cnt_nxt = '0;
               if (!w_rx_s) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = DATA;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         DATA: begin
            if (r_cnt == TC_FULL) begin
               w_cnt_nxt            = '0;
               w_shift_nxt[r_idx]   = w_rx_s;
               if (r_idx == IDX_LAST) begin
                  w_state_nxt = STOP;
               end else begin
                  w_idx_nxt = r_idx + IW'(1);
               end
            end
         end
         STOP: begin
            if (r_cnt == TC_FULL) begin
               w_cnt_nxt   = '0;
               w_state_nxt = IDLE;
               if (w_rx_s) begin
                  w_data_nxt  = r_shift;
                  w_valid_nxt = 1'b1;
               end else begin
                  w_ferr_nxt  = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign data_out   = r_data;
   assign data_valid = r_valid;
   assign frame_err  = r_ferr;
   assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_bit_4_rx.sv
// Scoreboard bench for bit_4_rx: a nominal-rate instance (16 clk/bit) and a
// rate-tolerance instance (200 clk/bit driven 3% slow).
module tb_bit_4_rx;

   localparam int CPB   = 16;
   localparam int CPB_S = 200;
   localparam int PER_S = 206;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx    = 1'b1;
   logic       rx2   = 1'b1;
   logic [7:0] data_out;
   logic       dv;
   logic       fe;
   logic       busy;
   logic [7:0] data_out2;
   logic       dv2;
   logic       fe2;
   logic       busy2;

   bit_4_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) u_dut (
      .clk_in     (clk),
      .rst_n      (rst_n),
      .rx_in      (rx),
      .data_out   (data_out),
      .data_valid (dv),
      .frame_err  (fe),
      .busy       (busy)
   );

   bit_4_rx #(.CLKS_PER_BIT(CPB_S), .DATA_BITS(8)) u_slow (
      .clk_in     (clk),
      .rst_n      (rst_n),
      .rx_in      (rx2),
      .data_out   (data_out2),
      .data_valid (dv2),
      .frame_err  (fe2),
      .busy       (busy2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      bit         ferr;
      logic [7:0] data;
   } exp_t;

   exp_t q[$];
   exp_t q_s[$];
   exp_t e;
   exp_t e2;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Main-instance monitor
   int v_last = -1;
   int v_prev = -1;
   bit pulse_d = 1'b0;

   always @(negedge clk) begin
      if (dv || fe) begin
         chk("pulse_exclusive", {31'd0, dv & fe}, 32'd0);
         chk("pulse_width", {31'd0, pulse_d}, 32'd0);
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse valid=%0b ferr=%0b required=none (cycle %0d)", dv, fe, cyc);
         end else begin
            e = q.pop_front();
            chk("pulse_kind_ferr", {31'd0, fe}, {31'd0, e.ferr});
            chk("pulse_data", {24'd0, data_out}, {24'd0, e.data});
         end
         if (dv) begin
            v_prev = v_last;
            v_last = cyc;
         end
      end
      pulse_d = dv | fe;
   end

   // Slow-instance monitor
   int s_cnt = 0;
   always @(negedge clk) begin
      if (dv2 || fe2) begin
         s_cnt++;
         if (q_s.size() == 0) begin
            total++;
            bad++;
            $display("FAIL slow_unexpected_pulse valid=%0b ferr=%0b required=none", dv2, fe2);
         end else begin
            e2 = q_s.pop_front();
            chk("slow_kind_ferr", {31'd0, fe2}, {31'd0, e2.ferr});
            chk("slow_data", {24'd0, data_out2}, {24'd0, e2.data});
         end
      end
   end

   // Drives one frame starting at the current negedge; returns cycle of the start edge.
   task automatic tx(input logic [7:0] b, input bit stop, input int per, input bit sel,
                     output int c_fall);
      if (sel) rx2 = 1'b0; else rx = 1'b0;
      c_fall = cyc;
      repeat (per) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         if (sel) rx2 = b[i]; else rx = b[i];
         repeat (per) @(negedge clk);
      end
      if (sel) rx2 = stop; else rx = stop;
      repeat (per) @(negedge clk);
   endtask

   int cf;

   initial begin
      #500000;
      $display("FAIL watchdog_timeout actual=cycle %0d required=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_data_out", {24'd0, data_out}, 32'd0);
      chk("reset_valid", {31'd0, dv}, 32'd0);
      chk("reset_ferr", {31'd0, fe}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Nominal frame 0xA5
      q.push_back('{1'b0, 8'hA5});
      tx(8'hA5, 1'b1, CPB, 1'b0, cf);
      chk("a5_valid_cycle", v_last, cf + 3 + 8 + 9 * CPB);
      repeat (10) @(negedge clk);
      chk("a5_busy_after", {31'd0, busy}, 32'd0);

      // 5-clock glitch on idle line
      rx = 1'b0;
      cf = cyc;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      chk("glitch_busy_high", {31'd0, busy}, 32'd1);
      repeat (7) @(negedge clk);
      chk("glitch_busy_cleared", {31'd0, busy}, 32'd0);
      repeat (20) @(negedge clk);

      // Frame 0x3C with low stop bit, then line held low
      q.push_back('{1'b1, 8'hA5});
      tx(8'h3C, 1'b0, CPB, 1'b0, cf);
      repeat (100) @(negedge clk);
      chk("held_low_busy", {31'd0, busy}, 32'd0);
      chk("held_low_data_out", {24'd0, data_out}, 32'hA5);
      rx = 1'b1;
      repeat (20) @(negedge clk);

      // Back-to-back 0x00 then 0xFF
      q.push_back('{1'b0, 8'h00});
      q.push_back('{1'b0, 8'hFF});
      tx(8'h00, 1'b1, CPB, 1'b0, cf);
      tx(8'hFF, 1'b1, CPB, 1'b0, cf);
      chk("b2b_spacing", v_last - v_prev, 160);
      repeat (20) @(negedge clk);

      // Reset during data bit 4 of 0x81, held until that frame has passed
      fork
         tx(8'h81, 1'b1, CPB, 1'b0, cf);
         begin
            repeat (88) @(negedge clk);
            chk("mid_frame_busy", {31'd0, busy}, 32'd1);
            rst_n = 1'b0;
            #1;
            chk("async_rst_data_out", {24'd0, data_out}, 32'd0);
            chk("async_rst_valid", {31'd0, dv}, 32'd0);
            chk("async_rst_ferr", {31'd0, fe}, 32'd0);
            chk("async_rst_busy", {31'd0, busy}, 32'd0);
         end
      join
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      q.push_back('{1'b0, 8'h81});
      tx(8'h81, 1'b1, CPB, 1'b0, cf);
      repeat (10) @(negedge clk);

      // Rate tolerance: 0x5A sent 3% slow
      q_s.push_back('{1'b0, 8'h5A});
      tx(8'h5A, 1'b1, PER_S, 1'b1, cf);
      repeat (50) @(negedge clk);
      chk("slow_pulse_count", s_cnt, 1);
      chk("slow_data_out", {24'd0, data_out2}, 32'h5A);

      chk("queues_drained", q.size() + q_s.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
